spi_seq_ctrl: RTL and testbench

//  SPI master sequencer driving the ADC/DAC configuration SPI bus from regfile controls.
//  - Launches one transaction per start pulse.
//  - Uses spi_rw_len, spi_ch_sel, spi_d_rise_align and spi_wdata.
//  - Returns captured read data as spi_rdata (channel 0) or spi_rdata1 (channel 1).
//  - Sits between the register file and the pads; two chip selects share one SCLK/MOSI.

---
 rtl/spi_seq_ctrl_if.sv | 29 ++
 rtl/spi_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_spi_seq_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/spi_seq_ctrl_if.sv
// Register-file <-> SPI sequencer bundle: start controls, transfer setup, pad signals and results.
// The master side is the register file (or bench); the slave side is spi_seq_ctrl.
interface spi_seq_ctrl_if;
   logic        start_wr;
   logic        start_rd;
   logic [4:0]  rw_len;
   logic        ch_sel;
   logic        d_rise_align;
   logic [31:0] wdata;
   logic        spi_miso0;
   logic        spi_miso1;
   logic        spi_sclk;
   logic [1:0]  spi_csn;
   logic        spi_mosi;
   logic [31:0] rdata;
   logic [31:0] rdata1;
   logic        busy;
   logic        done;

   modport master (
      output start_wr, start_rd, rw_len, ch_sel, d_rise_align, wdata, spi_miso0, spi_miso1,
      input  spi_sclk, spi_csn, spi_mosi, rdata, rdata1, busy, done
   );

   modport slave (
      input  start_wr, start_rd, rw_len, ch_sel, d_rise_align, wdata, spi_miso0, spi_miso1,
      output spi_sclk, spi_csn, spi_mosi, rdata, rdata1, busy, done
   );
endinterface

// File: rtl/spi_seq_ctrl.sv
// SPI master sequencer: one transaction per start pulse, two chip selects on a shared SCLK/MOSI,
// MSB-first shift-out, right-aligned per-channel read results.
module spi_seq_ctrl #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input logic           clk,
   input logic           rst,
   spi_seq_ctrl_if.slave bus
);

   localparam int CNT_MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int CNT_MAX   = (CNT_MAX_A > CS_HOLD) ? CNT_MAX_A : CS_HOLD;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [4:0]         r_bit;
   logic               r_last;
   logic               r_ch;
   logic               r_align;
   logic               r_is_rd;
   logic [31:0]        r_wdata;
   logic [31:0]        r_sr;
   logic               r_sclk;
   logic [1:0]         r_csn;
   logic               r_mosi;
   logic [31:0]        r_rdata;
   logic [31:0]        r_rdata1;
   logic               r_busy;
   logic               r_done;
   logic               w_miso;

   assign w_miso = r_ch ? bus.spi_miso1 : bus.spi_miso0;

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_bit    <= '0;
         r_last   <= 1'b0;
         r_ch     <= 1'b0;
         r_align  <= 1'b0;
         r_is_rd  <= 1'b0;
         r_wdata  <= '0;
         r_sr     <= '0;
         r_sclk   <= 1'b0;
         r_csn    <= 2'b11;
         r_mosi   <= 1'b0;
         r_rdata  <= '0;
         r_rdata1 <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start_wr || bus.start_rd) begin
                  r_state  <= S_SETUP;
                  r_cnt    <= CNT_W'(CS_SETUP - 1);
                  r_bit    <= bus.rw_len;
                  r_last   <= 1'b0;
                  r_ch     <= bus.ch_sel;
                  r_align  <= bus.d_rise_align;
                  r_is_rd  <= bus.start_rd;
                  r_wdata  <= bus.wdata;
                  r_sr     <= '0;
                  r_csn    <= bus.ch_sel ? 2'b01 : 2'b10;
                  r_mosi   <= bus.wdata[bus.rw_len];
                  r_busy   <= 1'b1;
               end
            end
            S_SETUP: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_state <= S_SHIFT;
                  r_cnt   <= CNT_W'(CLK_DIV - 1);
                  r_sclk  <= 1'b1;
                  if (r_align) r_sr <= {r_sr[30:0], w_miso};
               end
            end
            S_SHIFT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else if (r_sclk) begin
                  // Falling edge: optional capture, then present the next lower bit.
                  r_cnt  <= CNT_W'(CLK_DIV - 1);
                  r_sclk <= 1'b0;
                  r_last <= (r_bit == 5'd0);
                  if (!r_align) r_sr <= {r_sr[30:0], w_miso};
                  if (r_bit != 5'd0) begin
                     r_bit  <= r_bit - 5'd1;
                     r_mosi <= r_wdata[r_bit - 5'd1];
                  end
               end else if (r_last) begin
                  r_state <= S_HOLD;
                  r_cnt   <= CNT_W'(CS_HOLD - 1);
               end else begin
                  r_cnt  <= CNT_W'(CLK_DIV - 1);
                  r_sclk <= 1'b1;
                  if (r_align) r_sr <= {r_sr[30:0], w_miso};
               end
            end
            S_HOLD: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_state <= S_DONE;
                  r_csn   <= 2'b11;
                  r_done  <= 1'b1;
                  if (r_is_rd && !r_ch) r_rdata  <= r_sr;
                  if (r_is_rd &&  r_ch) r_rdata1 <= r_sr;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_mosi  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.spi_sclk = r_sclk;
   assign bus.spi_csn  = r_csn;
   assign bus.spi_mosi = r_mosi;
   assign bus.rdata    = r_rdata;
   assign bus.rdata1   = r_rdata1;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

endmodule

// File: tb/tb_spi_seq_ctrl.sv
// Directed plus randomized bench for spi_seq_ctrl: a bit-level device model drives MISO from SCLK
// edges and every transaction is scored against arithmetic expectations from the transfer rules.
module tb_spi_seq_ctrl;

   localparam int CLK_DIV  = 2;
   localparam int CS_SETUP = 1;
   localparam int CS_HOLD  = 1;
   localparam int MAX_CYC  = 400;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] exp_rdata  = '0;
   logic [31:0] exp_rdata1 = '0;

   spi_seq_ctrl_if bus();

   spi_seq_ctrl #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Selected device returns the word bit; the other device returns its complement.
   task automatic drive_miso(input bit ch, input bit b);
      bus.spi_miso0 = ch ? ~b : b;
      bus.spi_miso1 = ch ? b : ~b;
   endtask

   function automatic logic [31:0] len_mask(input int n);
      logic [63:0] m;
      m = (64'd1 << n) - 64'd1;
      return m[31:0];
   endfunction

   task automatic run_txn(input string name, input bit wr, input bit rd, input logic [4:0] len,
                          input bit ch, input bit align, input logic [31:0] wd,
                          input logic [31:0] mw, input bit poke);
      int          n;
      int          idx;
      int          cyc;
      int          busy_cyc;
      int          rises;
      int          dones;
      int          late_busy;
      bit          csn_bad;
      logic        prev_sclk;
      logic [1:0]  exp_csn;
      logic [31:0] mosi_got;
      logic [31:0] mask;
      n = int'(len) + 1;
      mask = len_mask(n);
      exp_csn = ch ? 2'b01 : 2'b10;
      busy_cyc = 0; rises = 0; dones = 0; late_busy = 0; csn_bad = 1'b0;
      mosi_got = '0; prev_sclk = 1'b0;

      @(negedge clk);
      bus.start_wr = wr; bus.start_rd = rd; bus.rw_len = len; bus.ch_sel = ch;
      bus.d_rise_align = align; bus.wdata = wd;
      if (align) begin
         drive_miso(ch, mw[n-1]);
         idx = n - 2;
      end else begin
         drive_miso(ch, $urandom_range(1));
         idx = n - 1;
      end
      @(negedge clk);
      bus.start_wr = 1'b0; bus.start_rd = 1'b0;
      // Scramble the setup inputs: the transaction must run from the latched copies.
      bus.rw_len = 5'($urandom); bus.ch_sel = ~ch; bus.d_rise_align = ~align; bus.wdata = $urandom;

      for (cyc = 0; cyc < MAX_CYC; cyc++) begin
         if (!bus.busy) break;
         busy_cyc++;
         if (bus.done) begin
            dones++;
            if (bus.spi_csn !== 2'b11) csn_bad = 1'b1;
         end else if (bus.spi_csn !== exp_csn) begin
            csn_bad = 1'b1;
         end
         if (bus.spi_sclk && !prev_sclk) begin
            rises++;
            mosi_got = {mosi_got[30:0], bus.spi_mosi};
         end
         if (bus.spi_sclk !== prev_sclk && (align ? !bus.spi_sclk : bus.spi_sclk) && idx >= 0) begin
            drive_miso(ch, mw[idx]);
            idx--;
         end
         prev_sclk = bus.spi_sclk;
         bus.start_wr = poke && (cyc == 5);
         @(negedge clk);
      end
      bus.start_wr = 1'b0;
      check({name, " timeout"}, 32'(cyc < MAX_CYC), 32'd1);
      for (int k = 0; k < 4; k++) begin
         if (bus.done) dones++;
         if (bus.busy) late_busy++;
         @(negedge clk);
      end

      if (rd) begin
         if (ch) exp_rdata1 = mw & mask;
         else    exp_rdata  = mw & mask;
      end
      check({name, " busy_cycles"}, 32'(busy_cyc), 32'(CS_SETUP + 2*CLK_DIV*n + CS_HOLD + 1));
      check({name, " sclk_rises"}, 32'(rises), 32'(n));
      check({name, " mosi_word"}, mosi_got & mask, wd & mask);
      check({name, " csn_ok"}, 32'(csn_bad), 32'd0);
      check({name, " done_pulses"}, 32'(dones), 32'd1);
      check({name, " idle_after"}, 32'(late_busy), 32'd0);
      check({name, " rdata"}, bus.rdata, exp_rdata);
      check({name, " rdata1"}, bus.rdata1, exp_rdata1);
   endtask

   task automatic check_reset_vals(input string name);
      check({name, " sclk"}, 32'(bus.spi_sclk), 32'd0);
      check({name, " csn"}, 32'(bus.spi_csn), 32'd3);
      check({name, " mosi"}, 32'(bus.spi_mosi), 32'd0);
      check({name, " busy"}, 32'(bus.busy), 32'd0);
      check({name, " done"}, 32'(bus.done), 32'd0);
      check({name, " rdata"}, bus.rdata, 32'd0);
      check({name, " rdata1"}, bus.rdata1, 32'd0);
   endtask

   initial begin
      int dones;
      bus.start_wr = 1'b0; bus.start_rd = 1'b0; bus.rw_len = '0; bus.ch_sel = 1'b0;
      bus.d_rise_align = 1'b0; bus.wdata = '0; bus.spi_miso0 = 1'b0; bus.spi_miso1 = 1'b0;

      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);

      run_txn("wr_a5",     1'b1, 1'b0, 5'd7,  1'b0, 1'b0, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b0);
      run_txn("rd_rise",   1'b0, 1'b1, 5'd31, 1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
      run_txn("rd_len1",   1'b0, 1'b1, 5'd0,  1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0);
      run_txn("rd_fall0",  1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'hDEAD_BEEF, 1'b0);
      run_txn("rd_fall1",  1'b0, 1'b1, 5'd31, 1'b1, 1'b0, 32'h0F0F_A5A5, 32'h1357_9BDF, 1'b0);
      run_txn("wr_poke",   1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 32'h0000_0ABC, 32'h0000_0000, 1'b1);
      run_txn("wr_rd_pair",1'b1, 1'b1, 5'd15, 1'b1, 1'b1, 32'h0000_55AA, 32'h0000_CAFE, 1'b0);

      for (int t = 0; t < 24; t++) begin
         bit is_rd;
         is_rd = 1'($urandom);
         run_txn($sformatf("rand%0d", t), ~is_rd, is_rd, 5'($urandom), 1'($urandom),
                 1'($urandom), $urandom, $urandom, 1'($urandom));
      end

      // Asynchronous reset in the middle of a long read.
      @(negedge clk);
      bus.start_rd = 1'b1; bus.rw_len = 5'd31; bus.ch_sel = 1'b1; bus.d_rise_align = 1'b1;
      bus.wdata = 32'hFFFF_FFFF; drive_miso(1'b1, 1'b1);
      @(negedge clk);
      bus.start_rd = 1'b0;
      repeat (CS_SETUP + 6) @(negedge clk);
      check("mid_shift busy", 32'(bus.busy), 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      exp_rdata = '0; exp_rdata1 = '0;
      check_reset_vals("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) dones++;
         @(negedge clk);
      end
      check("mid_reset no_done", 32'(dones), 32'd0);
      check("mid_reset rdata1_kept", bus.rdata1, exp_rdata1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
